pulse_period_meas: RTL and testbench

- Receiving end of the periodic tick interface produced by the codebase's config-driven pulse generators.
- Measures the clock-cycle spacing between single-cycle strobes on pulse_in and reports it in the same "max count" encoding the generators take: period of N+1 cycles reports N.
- Adds consecutive-match lock detection and a missing-pulse timeout.
- Used by firmware to verify tick rates (e.g. the 1 us tick) and by hardware watchdog logic.

---
 rtl/pulse_meas_pkg.sv | 12 +
 rtl/pulse_meas_lock_det.sv | 54 +++++
 rtl/pulse_period_meas.sv | 124 ++++++++++++
 tb/tb_pulse_period_meas.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meas_pkg.sv
// Shared types and defaults for the pulse period measurement block.
package pulse_meas_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } pm_state_t;

    localparam int LOCK_N_DEF = 4;

endpackage

// File: rtl/pulse_meas_lock_det.sv
// Lock detector: asserts locked once LOCK_N consecutive measurements have
// matched the one before them. clr has priority over a same-cycle measurement.
module pulse_meas_lock_det
    import pulse_meas_pkg::*;
#(
    parameter int WD     = 10,
    parameter int LOCK_N = LOCK_N_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          meas_valid,
    input  logic [WD-1:0] meas_cnt,
    output logic          locked
);

    localparam int MW = $clog2(LOCK_N + 1);

    logic [WD-1:0] prev_val;
    logic          prev_vld;
    logic [MW-1:0] match_cnt;
    logic [MW-1:0] match_nxt;

    function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
        return (v == MW'(LOCK_N)) ? v : v + 1'b1;
    endfunction

    always_comb begin
        match_nxt = match_cnt;
        if (prev_vld) begin
            match_nxt = (meas_cnt == prev_val) ? sat_inc(match_cnt) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            prev_vld  <= 1'b0;
            match_cnt <= '0;
            locked    <= 1'b0;
        end else if (meas_valid) begin
            prev_vld  <= 1'b1;
            match_cnt <= match_nxt;
            locked    <= (match_nxt == MW'(LOCK_N));
        end
    end

    // Reference value only matters while prev_vld is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (meas_valid) begin
            prev_val <= meas_cnt;
        end
    end

endmodule

// File: rtl/pulse_period_meas.sv
// Measures spacing between strobes on pulse_in (period N+1 reports N), with
// lock detection and a missing-pulse timeout. PULSE_MEAS_MINMAX_EN adds min/max tracking.
module pulse_period_meas
    import pulse_meas_pkg::*;
#(
    parameter int WD     = 10,
    parameter int LOCK_N = LOCK_N_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_en,
    input  logic [WD-1:0] cfg_timeout,
    input  logic          pulse_in,
    output logic [WD-1:0] meas_cnt,
    output logic          meas_valid,
    output logic          locked,
    output logic          timeout,
    output logic [WD-1:0] meas_min,
    output logic [WD-1:0] meas_max,
    input  logic          cfg_mm_clr
);

    pm_state_t     state;
    pm_state_t     state_nxt;
    logic [WD-1:0] cnt;
    logic [WD-1:0] cnt_nxt;
    logic          meas_upd;
    logic          tmo_nxt;
    logic          lock_clr;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        meas_upd  = 1'b0;
        tmo_nxt   = 1'b0;
        lock_clr  = 1'b0;
        if (!cfg_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            lock_clr  = 1'b1;
        end else begin
            case (state)
                IDLE: state_nxt = WAIT_FIRST;
                WAIT_FIRST: begin
                    if (pulse_in) begin
                        cnt_nxt   = '0;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    // A pulse arriving on the timeout cycle still counts as a measurement.
                    if (pulse_in) begin
                        meas_upd = 1'b1;
                        cnt_nxt  = '0;
                    end else if (cnt == cfg_timeout) begin
                        tmo_nxt   = 1'b1;
                        lock_clr  = 1'b1;
                        state_nxt = WAIT_FIRST;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            meas_cnt   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            meas_valid <= meas_upd;
            timeout    <= tmo_nxt;
            if (meas_upd) begin
                meas_cnt <= cnt;
            end
        end
    end

    // Lock detection runs one cycle behind the registered measurement.
    pulse_meas_lock_det #(
        .WD     (WD),
        .LOCK_N (LOCK_N)
    ) u_lock_det (
        .clk        (clk),
        .reset      (reset),
        .clr        (lock_clr),
        .meas_valid (meas_valid),
        .meas_cnt   (meas_cnt),
        .locked     (locked)
    );

`ifdef PULSE_MEAS_MINMAX_EN
    logic mm_have;

    always_ff @(posedge clk) begin
        if (reset || cfg_mm_clr) begin
            mm_have  <= 1'b0;
            meas_min <= '0;
            meas_max <= '0;
        end else if (meas_upd) begin
            mm_have <= 1'b1;
            if (!mm_have || cnt < meas_min) begin
                meas_min <= cnt;
            end
            if (!mm_have || cnt > meas_max) begin
                meas_max <= cnt;
            end
        end
    end
`else
    logic unused_mm_clr;
    assign unused_mm_clr = cfg_mm_clr;
    assign meas_min      = '0;
    assign meas_max      = '0;
`endif

endmodule

// File: tb/tb_pulse_period_meas.sv
// Randomized scoreboard bench for pulse_period_meas; the reference model works
// from pulse timestamps and a history of recent measurements.
module tb_pulse_period_meas;

    localparam int WD     = 10;
    localparam int LOCK_N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_en;
    logic [WD-1:0] cfg_timeout;
    logic          pulse_in;
    logic          cfg_mm_clr;
    logic [WD-1:0] meas_cnt;
    logic          meas_valid;
    logic          locked;
    logic          timeout;
    logic [WD-1:0] meas_min;
    logic [WD-1:0] meas_max;

    pulse_period_meas #(.WD(WD), .LOCK_N(LOCK_N)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_en      (cfg_en),
        .cfg_timeout (cfg_timeout),
        .pulse_in    (pulse_in),
        .meas_cnt    (meas_cnt),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .timeout     (timeout),
        .meas_min    (meas_min),
        .meas_max    (meas_max),
        .cfg_mm_clr  (cfg_mm_clr)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int checks   = 0;
    int failures = 0;

    typedef enum {EV_MEAS, EV_TMO, EV_LOCK} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       edge_n;
        int       val;
        int       mn;
        int       mx;
    } ev_t;

    ev_t expq[$];

    // Reference model state: mode 0 = disabled, 1 = awaiting reference pulse, 2 = timing
    int m_mode    = 0;
    int m_last    = 0;
    int m_hist[$];
    bit m_pend    = 0;
    int m_pend_val = 0;
    bit m_locked  = 0;
    bit m_mm_have = 0;
    int m_min     = 0;
    int m_max     = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
        end
    endfunction

    function automatic bit hist_all_equal();
        if (m_hist.size() != LOCK_N + 1) return 1'b0;
        foreach (m_hist[i]) begin
            if (m_hist[i] != m_hist[0]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void push_ev(input ev_kind_t k, input int e, input int v);
        ev_t ev;
        ev.kind   = k;
        ev.edge_n = e;
        ev.val    = v;
        ev.mn     = m_min;
        ev.mx     = m_max;
        expq.push_back(ev);
    endfunction

    // Predict what happens at clock edge e given the inputs currently driven.
    function automatic void model_edge(input int e);
        bit clr;
        bit new_lock;
        int gap;
        if (reset) begin
            m_mode = 0;
            m_hist.delete();
            m_pend = 0;
            m_mm_have = 0;
            m_min = 0;
            m_max = 0;
            new_lock = 0;
        end else begin
            gap = e - m_last;
            clr = !cfg_en || (m_mode == 2 && !pulse_in && gap == int'(cfg_timeout) + 1);
            if (clr) begin
                m_hist.delete();
            end else if (m_pend) begin
                m_hist.push_back(m_pend_val);
                if (m_hist.size() > LOCK_N + 1) void'(m_hist.pop_front());
            end
            m_pend = 0;
            new_lock = hist_all_equal();
`ifdef PULSE_MEAS_MINMAX_EN
            if (cfg_mm_clr) begin
                m_mm_have = 0;
                m_min = 0;
                m_max = 0;
            end
`endif
            if (!cfg_en) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (pulse_in) begin
                    m_mode = 2;
                    m_last = e;
                end
            end else if (pulse_in) begin
                m_pend = 1;
                m_pend_val = gap - 1;
                m_last = e;
`ifdef PULSE_MEAS_MINMAX_EN
                if (!cfg_mm_clr) begin
                    if (!m_mm_have || gap - 1 < m_min) m_min = gap - 1;
                    if (!m_mm_have || gap - 1 > m_max) m_max = gap - 1;
                    m_mm_have = 1;
                end
`endif
                push_ev(EV_MEAS, e, gap - 1);
            end else if (gap == int'(cfg_timeout) + 1) begin
                m_mode = 1;
                push_ev(EV_TMO, e, 0);
            end
        end
        if (new_lock != m_locked) push_ev(EV_LOCK, e, int'(new_lock));
        m_locked = new_lock;
    endfunction

    // Monitor: pops the expected event for every output the DUT presents.
    bit seen_locked = 1'b0;
    always @(negedge clk) begin
        ev_t ev;
        while (expq.size() > 0 && expq[0].edge_n < edges) begin
            ev = expq.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_event: kind=%0d expected at edge %0d, now edge %0d", ev.kind, ev.edge_n, edges);
        end
        if (meas_valid === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_meas: got meas_cnt=%0d, required no event", meas_cnt);
            end else begin
                ev = expq.pop_front();
                check("meas_kind", int'(ev.kind == EV_MEAS), 1);
                check("meas_edge", edges, ev.edge_n);
                check("meas_cnt", int'(meas_cnt), ev.val);
                check("meas_min", int'(meas_min), ev.mn);
                check("meas_max", int'(meas_max), ev.mx);
            end
        end
        if (timeout === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_timeout: got timeout=1, required no event");
            end else begin
                ev = expq.pop_front();
                check("tmo_kind", int'(ev.kind == EV_TMO), 1);
                check("tmo_edge", edges, ev.edge_n);
            end
        end
        if (locked !== seen_locked) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_lock_change: got locked=%0b, required %0b", locked, seen_locked);
            end else begin
                ev = expq.pop_front();
                check("lock_kind", int'(ev.kind == EV_LOCK), 1);
                check("lock_edge", edges, ev.edge_n);
                check("lock_level", int'(locked), ev.val);
            end
            seen_locked = locked;
        end
    end

    task automatic tick(input bit p);
        pulse_in = p;
        model_edge(edges + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic gap_pulse(input int g);
        repeat (g - 1) tick(1'b0);
        tick(1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_meas_cnt"}, int'(meas_cnt), 0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
        check({tag, "_meas_min"}, int'(meas_min), 0);
        check({tag, "_meas_max"}, int'(meas_max), 0);
    endtask

    initial begin
        int t;
        int p;
        int n;
        reset       = 1'b1;
        cfg_en      = 1'b0;
        pulse_in    = 1'b0;
        cfg_mm_clr  = 1'b0;
        cfg_timeout = 10'd20;
        repeat (3) tick(1'b0);
        check_all_zero("reset");

        // Steady period of 10 cycles
        reset  = 1'b0;
        cfg_en = 1'b1;
        repeat (2) tick(1'b0);
        tick(1'b1);
        repeat (8) gap_pulse(10);
        check("steady_locked", int'(locked), 1);

        // Timeout after a lone pulse, then re-measure
        cfg_en = 1'b0;
        tick(1'b0);
        cfg_timeout = 10'd15;
        cfg_en = 1'b1;
        tick(1'b0);
        tick(1'b1);
        repeat (20) tick(1'b0);
        gap_pulse(3);
        gap_pulse(5);

        // Boundary: gap 16 measures, gap 17 times out
        gap_pulse(16);
        repeat (16) tick(1'b0);
        tick(1'b1);
        gap_pulse(5);

        // Lock, lose lock on one long period, relock
        repeat (6) gap_pulse(10);
        check("pre_loss_locked", int'(locked), 1);
        gap_pulse(11);
        repeat (6) gap_pulse(10);
        check("relocked", int'(locked), 1);

        // Disable mid-period, then reset mid-measurement
        repeat (4) tick(1'b0);
        cfg_en = 1'b0;
        tick(1'b0);
        tick(1'b0);
        check("disabled_locked", int'(locked), 0);
        cfg_en = 1'b1;
        tick(1'b0);
        tick(1'b1);
        repeat (3) gap_pulse(7);
        repeat (3) tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        check_all_zero("midreset");

        // Min/max tracking: periods 8, 12, 10, then clear and period 10
        tick(1'b0);
        tick(1'b1);
        gap_pulse(8);
        gap_pulse(12);
        gap_pulse(10);
        repeat (3) tick(1'b0);
        cfg_mm_clr = 1'b1;
        tick(1'b0);
        cfg_mm_clr = 1'b0;
        repeat (5) tick(1'b0);
        tick(1'b1);

        // Randomized bursts of near-constant periods
        for (int b = 0; b < 60; b++) begin
            if ($urandom_range(0, 5) == 0) begin
                cfg_en = 1'b0;
                tick(1'b0);
                t = $urandom_range(0, 30);
                cfg_timeout = WD'(t);
                cfg_en = 1'b1;
            end
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                tick(1'b0);
                reset = 1'b0;
            end
            p = $urandom_range(1, int'(cfg_timeout) + 3);
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                int g;
                g = ($urandom_range(0, 9) == 0) ? p + 1 : p;
                repeat (g - 1) begin
                    cfg_mm_clr = ($urandom_range(0, 31) == 0);
                    tick(1'b0);
                    cfg_mm_clr = 1'b0;
                end
                tick(1'b1);
            end
        end

        repeat (5) tick(1'b0);
        @(negedge clk);
        #1;
        check("events_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
